// File: rtl/or_vector_checker.sv
// Checks a stream of (a, b, c) vectors against c == a | b and keeps pass/fail counts plus the first failing vector.
// Optional build macro OR_VECTOR_CHECKER_HALT_ON_FAIL_EN: stop the run when the first mismatch is counted.
module or_vector_checker #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W-1:0]     in_c,
  input  logic             in_last,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [W-1:0]     ff_a,
  output logic [W-1:0]     ff_b,
  output logic [W-1:0]     ff_c,
  output logic             ff_vld,
  output logic             done,
  output logic             all_pass
);

  // state   | meaning
  // IDLE    | nothing accepted since reset/clr (a lone last vector may sit in capture)
  // RUN     | vectors being accepted and evaluated
  // DONE    | run finished, results frozen until clr/reset
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic             cap_vld_q, cap_vld_d;
  logic             cap_last_q, cap_last_d;
  logic [W-1:0]     cap_a_q, cap_a_d;
  logic [W-1:0]     cap_b_q, cap_b_d;
  logic [W-1:0]     cap_c_q, cap_c_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [W-1:0]     ff_a_q, ff_a_d;
  logic [W-1:0]     ff_b_q, ff_b_d;
  logic [W-1:0]     ff_c_q, ff_c_d;
  logic             ff_vld_q, ff_vld_d;

  logic cap_match;
  logic cap_fail;
  logic end_run;
  logic accept;

  assign cap_match = ((cap_a_q | cap_b_q) == cap_c_q);
  assign cap_fail  = cap_vld_q && !cap_match;

`ifdef OR_VECTOR_CHECKER_HALT_ON_FAIL_EN
  assign end_run = cap_vld_q && (cap_last_q || (cap_fail && !ff_vld_q));
`else
  assign end_run = cap_vld_q && cap_last_q;
`endif

  // Ready drops while the block commits to DONE so no vector is accepted and then stranded.
  assign in_ready = (state_q != ST_DONE) && !end_run;
  assign accept   = in_valid && in_ready && !clr;

  always_comb begin
    state_d    = state_q;
    cap_vld_d  = accept;
    cap_last_d = cap_last_q;
    cap_a_d    = cap_a_q;
    cap_b_d    = cap_b_q;
    cap_c_d    = cap_c_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    ff_a_d     = ff_a_q;
    ff_b_d     = ff_b_q;
    ff_c_d     = ff_c_q;
    ff_vld_d   = ff_vld_q;

    if (accept) begin
      cap_a_d    = in_a;
      cap_b_d    = in_b;
      cap_c_d    = in_c;
      cap_last_d = in_last;
    end

    if (cap_vld_q) begin
      if (cap_match) begin
        if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 1'b1;
      end else begin
        if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
        if (!ff_vld_q) begin
          ff_a_d   = cap_a_q;
          ff_b_d   = cap_b_q;
          ff_c_d   = cap_c_q;
          ff_vld_d = 1'b1;
        end
      end
    end

    case (state_q)
      ST_IDLE: if (accept && !in_last) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (end_run) state_d = ST_DONE;

    if (clr) begin
      state_d    = ST_IDLE;
      cap_vld_d  = 1'b0;
      cap_last_d = 1'b0;
      cap_a_d    = '0;
      cap_b_d    = '0;
      cap_c_d    = '0;
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      ff_a_d     = '0;
      ff_b_d     = '0;
      ff_c_d     = '0;
      ff_vld_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q    <= ST_IDLE;
      cap_vld_q  <= 1'b0;
      cap_last_q <= 1'b0;
      cap_a_q    <= '0;
      cap_b_q    <= '0;
      cap_c_q    <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      ff_a_q     <= '0;
      ff_b_q     <= '0;
      ff_c_q     <= '0;
      ff_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_vld_q  <= cap_vld_d;
      cap_last_q <= cap_last_d;
      cap_a_q    <= cap_a_d;
      cap_b_q    <= cap_b_d;
      cap_c_q    <= cap_c_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      ff_a_q     <= ff_a_d;
      ff_b_q     <= ff_b_d;
      ff_c_q     <= ff_c_d;
      ff_vld_q   <= ff_vld_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign ff_a     = ff_a_q;
  assign ff_b     = ff_b_q;
  assign ff_c     = ff_c_q;
  assign ff_vld   = ff_vld_q;
  assign done     = (state_q == ST_DONE);
  assign all_pass = done && (fail_cnt_q == '0);

endmodule

// File: tb/tb_or_vector_checker.sv
// Bench for or_vector_checker: two instances (CNT_W=8 and CNT_W=2) driven identically and checked every cycle
// against a transaction-level model, plus literal checks of the worked examples.
module tb_or_vector_checker;

`ifdef OR_VECTOR_CHECKER_HALT_ON_FAIL_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_X = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [3:0] in_a = '0, in_b = '0, in_c = '0;

  logic       r8_ready, r8_ffv, r8_done, r8_ap;
  logic [7:0] r8_pass, r8_fail;
  logic [3:0] r8_ffa, r8_ffb, r8_ffc;
  logic       r2_ready, r2_ffv, r2_done, r2_ap;
  logic [1:0] r2_pass, r2_fail;
  logic [3:0] r2_ffa, r2_ffb, r2_ffc;

  or_vector_checker #(.W(4), .CNT_W(8)) dut8 (
    .CLK(CLK), .RST_X(RST_X), .clr(clr), .in_valid(in_valid), .in_ready(r8_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_last(in_last),
    .pass_cnt(r8_pass), .fail_cnt(r8_fail), .ff_a(r8_ffa), .ff_b(r8_ffb), .ff_c(r8_ffc),
    .ff_vld(r8_ffv), .done(r8_done), .all_pass(r8_ap));

  or_vector_checker #(.W(4), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST_X(RST_X), .clr(clr), .in_valid(in_valid), .in_ready(r2_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_last(in_last),
    .pass_cnt(r2_pass), .fail_cnt(r2_fail), .ff_a(r2_ffa), .ff_b(r2_ffb), .ff_c(r2_ffc),
    .ff_vld(r2_ffv), .done(r2_done), .all_pass(r2_ap));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: unbounded counts, first-fail record, and at most one vector awaiting evaluation.
  int         m_pass, m_fail;
  logic [3:0] m_ffa, m_ffb, m_ffc;
  bit         m_ffv, m_done;
  bit         m_pend, m_pl;
  logic [3:0] m_pa, m_pb, m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  function automatic bit m_ready();
    bit halting;
    halting = HALT && m_pend && ((m_pa | m_pb) != m_pc) && !m_ffv;
    return !m_done && !(m_pend && m_pl) && !halting;
  endfunction

  task automatic model_clear();
    m_pass = 0; m_fail = 0;
    m_ffa = '0; m_ffb = '0; m_ffc = '0;
    m_ffv = 1'b0; m_done = 1'b0; m_pend = 1'b0; m_pl = 1'b0;
    m_pa = '0; m_pb = '0; m_pc = '0;
  endtask

  task automatic model_edge();
    bit acc;
    acc = in_valid && m_ready() && !clr;
    if (clr) begin
      model_clear();
      return;
    end
    if (m_pend) begin
      if ((m_pa | m_pb) == m_pc) m_pass++;
      else begin
        m_fail++;
        if (!m_ffv) begin
          m_ffa = m_pa; m_ffb = m_pb; m_ffc = m_pc; m_ffv = 1'b1;
          if (HALT) m_done = 1'b1;
        end
      end
      if (m_pl) m_done = 1'b1;
    end
    m_pend = acc;
    if (acc) begin
      m_pa = in_a; m_pb = in_b; m_pc = in_c; m_pl = in_last;
    end
  endtask

  task automatic compare_all();
    chk("rdy8",  32'(r8_ready), 32'(m_ready()));
    chk("pass8", 32'(r8_pass),  32'(sat(m_pass, 255)));
    chk("fail8", 32'(r8_fail),  32'(sat(m_fail, 255)));
    chk("ffa8",  32'(r8_ffa),   32'(m_ffa));
    chk("ffb8",  32'(r8_ffb),   32'(m_ffb));
    chk("ffc8",  32'(r8_ffc),   32'(m_ffc));
    chk("ffv8",  32'(r8_ffv),   32'(m_ffv));
    chk("done8", 32'(r8_done),  32'(m_done));
    chk("ap8",   32'(r8_ap),    32'(m_done && m_fail == 0));
    chk("rdy2",  32'(r2_ready), 32'(m_ready()));
    chk("pass2", 32'(r2_pass),  32'(sat(m_pass, 3)));
    chk("fail2", 32'(r2_fail),  32'(sat(m_fail, 3)));
    chk("ffa2",  32'(r2_ffa),   32'(m_ffa));
    chk("ffv2",  32'(r2_ffv),   32'(m_ffv));
    chk("done2", 32'(r2_done),  32'(m_done));
    chk("ap2",   32'(r2_ap),    32'(m_done && m_fail == 0));
  endtask

  task automatic drive(input bit v, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input bit l, input bit cl);
    in_valid = v; in_a = a; in_b = b; in_c = c; in_last = l; clr = cl;
  endtask

  task automatic step();
    @(negedge CLK);
    compare_all();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    compare_all();
    chk("rst_rdy", 32'(r8_ready), 32'd1);
    RST_X = 1'b1;

    // single last vector: 1010|1100 == 1110
    drive(1, 4'b1010, 4'b1100, 4'b1110, 1, 0); step();
    drive(0, '0, '0, '0, 0, 0); step();
    chk("e1_pass", 32'(r8_pass), 32'd1);
    chk("e1_fail", 32'(r8_fail), 32'd0);
    chk("e1_done", 32'(r8_done), 32'd1);
    chk("e1_ap",   32'(r8_ap),   32'd1);
    chk("e1_rdy",  32'(r8_ready), 32'd0);
    drive(1, 4'b0001, 4'b0000, 4'b0000, 1, 0); step(); step();
    chk("e1_hold", 32'(r8_pass), 32'd1);
    drive(0, '0, '0, '0, 0, 1); step();

    // three back-to-back vectors, two failing
    drive(1, 4'b1010, 4'b1100, 4'b1110, 0, 0); step();
    drive(1, 4'b0001, 4'b0010, 4'b0000, 0, 0); step();
    drive(1, 4'b0101, 4'b0000, 4'b0100, 1, 0); step();
    drive(0, '0, '0, '0, 0, 0); step(); step();
    chk("e2_pass", 32'(r8_pass), 32'd1);
    chk("e2_fail", 32'(r8_fail), HALT ? 32'd1 : 32'd2);
    chk("e2_ffa",  32'(r8_ffa),  32'b0001);
    chk("e2_ffb",  32'(r8_ffb),  32'b0010);
    chk("e2_ffc",  32'(r8_ffc),  32'b0000);
    chk("e2_ffv",  32'(r8_ffv),  32'd1);
    chk("e2_done", 32'(r8_done), 32'd1);
    chk("e2_ap",   32'(r8_ap),   32'd0);
    drive(0, '0, '0, '0, 0, 1); step();

    // five matches: narrow counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'b0011, 4'b0100, 4'b0111, 0, 0); step();
    end
    drive(0, '0, '0, '0, 0, 0); step(); step();
    chk("e3_pass2", 32'(r2_pass), 32'd3);
    chk("e3_pass8", 32'(r8_pass), 32'd5);
    chk("e3_done",  32'(r8_done), 32'd0);
    drive(0, '0, '0, '0, 0, 1); step();

    // clr in the same cycle as an accept
    drive(1, 4'b1000, 4'b0001, 4'b1001, 0, 0); step();
    drive(1, 4'b1000, 4'b0001, 4'b1001, 1, 1); step();
    drive(0, '0, '0, '0, 0, 0); step(); step();
    chk("e4_pass", 32'(r8_pass), 32'd0);
    chk("e4_fail", 32'(r8_fail), 32'd0);
    chk("e4_rdy",  32'(r8_ready), 32'd1);
    chk("e4_done", 32'(r8_done), 32'd0);

    // asynchronous reset with a vector in flight
    drive(1, 4'b0110, 4'b0001, 4'b0111, 0, 0); step();
    drive(1, 4'b0110, 4'b0001, 4'b0000, 0, 0); step();
    drive(0, '0, '0, '0, 0, 0);
    #2 RST_X = 1'b0;
    #1;
    model_clear();
    chk("e5_pass", 32'(r8_pass), 32'd0);
    chk("e5_fail", 32'(r8_fail), 32'd0);
    chk("e5_ffv",  32'(r8_ffv),  32'd0);
    chk("e5_rdy",  32'(r8_ready), 32'd1);
    compare_all();
    @(posedge CLK);
    #1 RST_X = 1'b1;
    step(); step();
    chk("e5_pass_rel", 32'(r8_pass), 32'd0);
    chk("e5_fail_rel", 32'(r8_fail), 32'd0);

    // randomized stream
    for (int i = 0; i < 400; i++) begin
      logic [3:0] a, b, c;
      bit v, l, cl;
      a  = 4'($urandom);
      b  = 4'($urandom);
      c  = ($urandom_range(0, 1) == 0) ? (a | b) : 4'($urandom);
      v  = ($urandom_range(0, 9) < 7);
      l  = ($urandom_range(0, 9) == 0);
      cl = m_done ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      drive(v, a, b, c, l, cl);
      step();
    end
    drive(0, '0, '0, '0, 0, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/or_vector_checker.md
OR_VECTOR_CHECKER -- requirements
Module: or_vector_checker

Interface
REQ-001 SHALL have parameter W, default 4, operand/result width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, width of the pass and fail counters.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_X  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous clear of all results; returns the block to IDLE.
REQ-006 SHALL have port in_valid  input  1  vector present on in_a/in_b/in_c/in_last.
REQ-007 SHALL have port in_ready  output  1  block accepts a vector this cycle.
REQ-008 SHALL have ports in_a, in_b, in_c  input  W each  operands and DUT result under check.
REQ-009 SHALL have port in_last  input  1  marks the final vector of a run.
REQ-010 SHALL have ports pass_cnt, fail_cnt  output  CNT_W each  matching and mismatching vector counts.
REQ-011 SHALL have ports ff_a, ff_b, ff_c  output  W each  first failing vector; ff_vld  output  1  marks them valid.
REQ-012 SHALL have ports done  output  1  run complete, and all_pass  output  1  equal to done AND fail_cnt==0.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready=1 in IDLE and RUN, and in_ready=0 in DONE.
REQ-015 SHALL accept a vector only on a cycle where in_valid && in_ready; in_* SHALL be ignored on all other cycles.
REQ-016 SHALL move IDLE->RUN on the first accept; if that vector has in_last=1, SHALL go IDLE->DONE directly via the evaluation stage.
REQ-017 SHALL register each accepted vector in a capture stage (edge N) and compare at edge N+1: expected = in_a | in_b, bitwise, W bits, compared against the registered in_c.
REQ-018 SHALL increment pass_cnt on a match or fail_cnt on a mismatch at edge N+1; counter outputs SHALL be visible after edge N+1 (latency 1 cycle from accept).
REQ-019 SHALL saturate each counter at 2^CNT_W-1, with no wrap to 0.
REQ-020 SHALL, on the first mismatch since reset/clr, latch ff_a/ff_b/ff_c and set ff_vld=1; later mismatches SHALL NOT overwrite the latched vector.
REQ-021 SHALL enter DONE at edge N+1 for an accepted vector with in_last=1, and assert done there.
REQ-022 SHALL accept back-to-back vectors (one per cycle) in RUN, with no bubbles.
REQ-023 SHALL, when clr=1 at an edge in any state: zero counters, ff_*, ff_vld and done; flush the capture stage; enter IDLE.
REQ-024 SHALL give clr priority over a simultaneous accept; that vector SHALL be discarded and uncounted.
REQ-025 SHALL hold DONE (in_ready=0, results stable) until clr or reset.

Reset
REQ-026 SHALL, while RST_X=0, immediately force: state=IDLE, in_ready=1, pass_cnt=0, fail_cnt=0, ff_a/ff_b/ff_c=0, ff_vld=0, done=0, all_pass=0, capture stage empty.
REQ-027 SHALL discard an in-flight captured vector on reset mid-run; it SHALL NOT be counted after release.

Configuration
REQ-028 SHALL support the macro OR_VECTOR_CHECKER_HALT_ON_FAIL_EN.
REQ-029 SHALL, with the macro defined, enter DONE at the edge where the first mismatch is counted (done=1, in_ready=0), regardless of in_last.
REQ-030 SHALL, without the macro, continue checking after mismatches until an in_last vector is evaluated.

Verification
REQ-031 SHALL pass: W=4, accept a=1010, b=1100, c=1110, last=1 -> one cycle later pass_cnt=1, fail_cnt=0, done=1, all_pass=1, in_ready=0.
REQ-032 SHALL pass: macro undefined, three back-to-back vectors (1010|1100, c=1110), (0001|0010, c=0000), (0101|0000, c=0100, last) -> pass=1, fail=2, ff=0001/0010/0000, ff_vld=1, all_pass=0.
REQ-033 SHALL pass: macro defined, same stream as REQ-032 -> DONE after the 2nd vector is evaluated, pass=1, fail=1, 3rd vector not accepted.
REQ-034 SHALL pass: CNT_W=2, five matching vectors -> pass_cnt stays at 3.
REQ-035 SHALL pass: clr asserted in the same cycle as an accepted vector -> counters 0, state IDLE, vector never counted.
REQ-036 SHALL pass: RST_X pulled low mid-cycle one cycle after an accept -> outputs zero immediately; after release, pass_cnt=fail_cnt=0.
